// File: rtl/keyboard_direction.sv
// Keyboard direction decoder: receives PS/2 frames from a keyboard and turns
// extended arrow make/break codes into a held one-hot direction plus a move
// pulse, and the S key into a start_key level. Partial or corrupt frames are
// dropped with a one-cycle frame_error pulse.
module keyboard_direction #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       start,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [3:0] direction,
  output logic       move,
  output logic       start_key,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  rx_state_t      state, state_next;
  logic           ps2_clk_meta, ps2_clk_sync, ps2_clk_prev;
  logic           ps2_dat_meta, ps2_dat_sync;
  logic           ps2_fall;
  logic [TW-1:0]  timeout_cnt;
  logic           timeout_hit;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_reg;
  logic           parity_bit;
  logic           frame_ok, frame_bad, frame_timeout;
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           ext, brk;
  logic [3:0]     arrow_code;

  // Two-flop synchronizers, preset to the idle-high bus level so leaving reset never looks like a clock edge
  always_ff @(posedge clock) begin
    if (start) begin
      ps2_clk_meta <= 1'b1;
      ps2_clk_sync <= 1'b1;
      ps2_clk_prev <= 1'b1;
      ps2_dat_meta <= 1'b1;
      ps2_dat_sync <= 1'b1;
    end else begin
      ps2_clk_meta <= PS2_CLK;
      ps2_clk_sync <= ps2_clk_meta;
      ps2_clk_prev <= ps2_clk_sync;
      ps2_dat_meta <= PS2_DAT;
      ps2_dat_sync <= ps2_dat_meta;
    end
  end

  assign ps2_fall    = ps2_clk_prev & ~ps2_clk_sync;
  assign timeout_hit = (state != IDLE) && !ps2_fall &&
                       (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counting quiet cycles inside a frame; any keyboard clock edge or idling restarts it
  always_ff @(posedge clock) begin
    if (start || state == IDLE || ps2_fall || timeout_hit) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  // Receiver state register
  always_ff @(posedge clock) begin
    if (start) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Receiver next-state logic with frame accept/reject decisions made on the stop-bit edge
  always_comb begin
    state_next    = state;
    frame_ok      = 1'b0;
    frame_bad     = 1'b0;
    frame_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (ps2_fall && !ps2_dat_sync) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (ps2_fall && bit_cnt == 3'd7) begin
          state_next = PARITY;
        end
      end
      PARITY: begin
        if (ps2_fall) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (ps2_fall) begin
          state_next = IDLE;
          if (ps2_dat_sync && (^{shift_reg, parity_bit})) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next    = IDLE;
      frame_timeout = 1'b1;
    end
  end

  // Shift data bits in LSB first and capture the parity bit
  always_ff @(posedge clock) begin
    if (start) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
      end
      if (ps2_fall && state == DATA) begin
        shift_reg <= {ps2_dat_sync, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (ps2_fall && state == PARITY) begin
        parity_bit <= ps2_dat_sync;
      end
    end
  end

  // Hand a checked byte to the decoder one cycle after the stop edge, or flag the discard
  always_ff @(posedge clock) begin
    if (start) begin
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= frame_ok;
      byte_data   <= shift_reg;
      frame_error <= frame_bad | frame_timeout;
    end
  end

  // Map arrow scan codes to their one-hot direction (zero when not an arrow)
  always_comb begin
    arrow_code = 4'b0000;
    case (byte_data)
      8'h75:   arrow_code = 4'b1000;
      8'h72:   arrow_code = 4'b0100;
      8'h6B:   arrow_code = 4'b0010;
      8'h74:   arrow_code = 4'b0001;
      default: arrow_code = 4'b0000;
    endcase
  end

  // Scan-code decoder: prefix bytes set flags, code bytes act on them and clear them
  always_ff @(posedge clock) begin
    if (start) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      direction <= 4'b0000;
      move      <= 1'b0;
      start_key <= 1'b0;
    end else begin
      move <= 1'b0;
      if (byte_valid) begin
        if (byte_data == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_data == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (ext && arrow_code != 4'b0000) begin
            if (!brk) begin
              direction <= arrow_code;
              move      <= 1'b1;
            end else if (direction == arrow_code) begin
              direction <= 4'b0000;
            end
          end else if (!ext && byte_data == 8'h1B) begin
            start_key <= !brk;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keyboard_direction.sv
// Directed bench for keyboard_direction: drives PS/2 frames bit by bit and
// compares the decoded outputs against hand-worked expectations.
module tb_keyboard_direction;

  localparam int TIMEOUT = 400;
  localparam int HALF    = 20;
  localparam int GAP     = 40;

  logic       clock;
  logic       start;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [3:0] direction;
  logic       move;
  logic       start_key;
  logic       frame_error;

  int vector_count;
  int miscompare_count;
  int move_count, err_count, move_double, err_double;
  int move_base, err_base;
  logic move_last, err_last;

  keyboard_direction #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock),
    .start(start),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .direction(direction),
    .move(move),
    .start_key(start_key),
    .frame_error(frame_error)
  );

  initial clock = 1'b0;
  // 50 MHz system clock
  always #10 clock = ~clock;

  // Count pulses and back-to-back highs of the pulse outputs
  always @(negedge clock) begin
    if (move) move_count++;
    if (move && move_last) move_double++;
    if (frame_error) err_count++;
    if (frame_error && err_last) err_double++;
    move_last = move;
    err_last  = frame_error;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Send the first nbits of an 11-bit frame (start, data LSB first, odd parity, stop)
  task automatic applyStimulus(input logic [7:0] data, input bit flip_parity,
                               input int nbits);
    logic [10:0] frame;
    logic        parity;
    parity = (~^data) ^ flip_parity;
    frame  = {1'b1, parity, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = frame[i];
      repeat (HALF) @(negedge clock);
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge clock);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (GAP) @(negedge clock);
  endtask

  task automatic markCounts();
    move_base = move_count;
    err_base  = err_count;
  endtask

  initial begin
    vector_count = 0; miscompare_count = 0;
    move_count = 0; err_count = 0; move_double = 0; err_double = 0;
    move_last = 1'b0; err_last = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    start   = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("reset_direction", 32'(direction), 32'h0);
    checkOutput("reset_move", 32'(move), 32'h0);
    checkOutput("reset_start_key", 32'(start_key), 32'h0);
    checkOutput("reset_frame_error", 32'(frame_error), 32'h0);
    start = 1'b0;
    repeat (10) @(negedge clock);

    // A lone keyboard clock pulse with data high is not a start bit
    markCounts();
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge clock);
    PS2_CLK = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clock);
    checkOutput("idle_one_no_error", 32'(err_count - err_base), 32'd0);

    // Up arrow make
    markCounts();
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h75, 1'b0, 11);
    checkOutput("up_direction", 32'(direction), 32'h8);
    checkOutput("up_move_pulses", 32'(move_count - move_base), 32'd1);
    checkOutput("up_no_error", 32'(err_count - err_base), 32'd0);

    // Left replaces up; break of up (not held) leaves left
    markCounts();
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h6B, 1'b0, 11);
    checkOutput("left_direction", 32'(direction), 32'h2);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'hF0, 1'b0, 11);
    applyStimulus(8'h75, 1'b0, 11);
    checkOutput("break_other_direction", 32'(direction), 32'h2);
    checkOutput("left_move_pulses", 32'(move_count - move_base), 32'd1);

    // Corrupt parity is discarded
    markCounts();
    applyStimulus(8'h75, 1'b1, 11);
    checkOutput("parity_error_pulses", 32'(err_count - err_base), 32'd1);
    checkOutput("parity_direction", 32'(direction), 32'h2);

    // Partial frame then silence times out; a clean frame follows
    markCounts();
    applyStimulus(8'hA5, 1'b0, 5);
    repeat (TIMEOUT + 100) @(negedge clock);
    checkOutput("timeout_error_pulses", 32'(err_count - err_base), 32'd1);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h72, 1'b0, 11);
    checkOutput("down_direction", 32'(direction), 32'h4);

    // S key make and break
    markCounts();
    applyStimulus(8'h1B, 1'b0, 11);
    checkOutput("s_make", 32'(start_key), 32'h1);
    applyStimulus(8'hF0, 1'b0, 11);
    applyStimulus(8'h1B, 1'b0, 11);
    checkOutput("s_break", 32'(start_key), 32'h0);
    checkOutput("s_no_move", 32'(move_count - move_base), 32'd0);
    checkOutput("s_direction_kept", 32'(direction), 32'h4);

    // Reset in the middle of data bit 5 of an E0 frame
    markCounts();
    applyStimulus(8'hE0, 1'b0, 6);
    PS2_DAT = 1'b1;
    repeat (5) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    checkOutput("midreset_direction", 32'(direction), 32'h0);
    checkOutput("midreset_start_key", 32'(start_key), 32'h0);
    checkOutput("midreset_move", 32'(move), 32'h0);
    checkOutput("midreset_frame_error", 32'(frame_error), 32'h0);
    start = 1'b0;
    repeat (TIMEOUT + 100) @(negedge clock);
    checkOutput("midreset_no_timeout", 32'(err_count - err_base), 32'd0);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h74, 1'b0, 11);
    checkOutput("right_direction", 32'(direction), 32'h1);
    checkOutput("right_move_pulses", 32'(move_count - move_base), 32'd1);

    checkOutput("move_single_cycle", 32'(move_double), 32'd0);
    checkOutput("error_single_cycle", 32'(err_double), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/keyboard_direction.md
KEYBOARD_DIRECTION -- requirements
Module: keyboard_direction

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of cycles without a PS/2 falling edge after which a partial frame is discarded (1 ms at 50 MHz).
REQ-002 Port clock  input  1  system clock (CLOCK_50); all logic is on its rising edge.
REQ-003 Port start  input  1  synchronous, active-high reset.
REQ-004 Port PS2_CLK  input  1  raw keyboard clock; asynchronous to clock.
REQ-005 Port PS2_DAT  input  1  raw keyboard data; asynchronous to clock.
REQ-006 Port direction  output  4  one-hot held arrow: [3] up, [2] down, [1] left, [0] right; 4'b0000 means no arrow held.
REQ-007 Port move  output  1  one-cycle pulse on every arrow make code, including typematic repeats.
REQ-008 Port start_key  output  1  level: S key held.
REQ-009 Port frame_error  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-010 PS2_CLK and PS2_DAT shall each pass through a 2-flop synchronizer; a falling edge is synchronized PS2_CLK going from 1 to 0 between consecutive cycles.
REQ-011 The frame receiver shall use states IDLE, DATA, PARITY and STOP, sampling synchronized PS2_DAT on each falling edge.
REQ-012 IDLE: a sample of 0 (start bit) moves to DATA with the bit count at 0; a sample of 1 stays in IDLE and no error is flagged.
REQ-013 DATA: 8 samples are shifted in LSB first, then the state moves to PARITY.
REQ-014 PARITY: the sample is stored, then the state moves to STOP.
REQ-015 STOP: a frame is valid if the stop sample is 1 and the 8 data bits plus parity contain an odd number of ones; the byte is delivered one cycle after that falling edge and the state returns to IDLE.
REQ-016 A failed stop or parity check shall pulse frame_error, deliver no byte, leave all decode flags unchanged and return to IDLE.
REQ-017 In any non-IDLE state, a count reaching TIMEOUT_CYCLES with no falling edge shall pulse frame_error and return to IDLE.
REQ-018 The timeout counter shall clear on every falling edge and while in IDLE.
REQ-019 Byte decoder flags: ext is set by 0xE0; brk is set by 0xF0.
REQ-020 Any byte other than 0xE0 or 0xF0 is a code byte; both flags clear in the cycle after it is delivered.
REQ-021 Extended make of 0x75/0x72/0x6B/0x74 (up/down/left/right) shall set direction to that one-hot value and pulse move in the same cycle.
REQ-022 Extended break of an arrow shall clear direction only if that arrow is the one currently held; otherwise direction is unchanged.
REQ-023 A new arrow make while another arrow is held replaces it (last pressed wins).
REQ-024 Non-extended 0x1B make sets start_key; 0x1B break clears it.
REQ-025 All other codes, and arrow codes received without ext, shall be ignored, and their flags cleared.
REQ-026 Latency from the falling edge that samples the stop bit to a direction/move update shall be at most 4 clock cycles.
REQ-027 move and frame_error shall never be high for more than one consecutive cycle.

Reset
REQ-028 While start is 1: state is IDLE; bit counter, timeout counter, ext and brk are 0; direction is 4'b0000; move, start_key and frame_error are 0.
REQ-029 A reset asserted mid-frame shall discard the partial frame; reception resumes at the next start bit after start deasserts.
REQ-030 Synchronizer flops shall reset to 1, the idle bus level, so reset release causes no false falling edge.

Verification
REQ-031 Frames E0, 75 with valid parity, 40 us bit period -> direction=4'b1000 and move pulses once for 1 cycle.
REQ-032 Frames E0 75, then E0 6B, then E0 F0 75 -> direction goes 1000, then 0010, and stays 0010 (break of a non-held key).
REQ-033 Frame 0x75 with the parity bit inverted -> frame_error pulses once and direction is unchanged.
REQ-034 Send start bit and 4 data bits, then idle for 50000 cycles -> frame_error pulses at the timeout; a following valid E0 72 gives direction=4'b0100.
REQ-035 Frames 1B, then F0 1B -> start_key goes 1, then 0, and move is never asserted.
REQ-036 Assert start for 1 cycle during data bit 5 of an E0 frame -> all outputs are 0; a following complete E0 74 gives direction=4'b0001.
